// File: rtl/flash_spi_responder_if.sv
// Byte-wide synchronous memory read port between the flash responder
// (master: issues strobes and addresses) and the backing memory (slave).
interface flash_spi_responder_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/flash_spi_responder.sv
// SPI flash read responder: oversamples mode-0 SPI pins in the system clock
// domain and answers READ (0x03), READ STATUS (0x05) and JEDEC ID (0x9F).
// READ data is fetched one byte ahead from a synchronous memory read port.
module flash_spi_responder #(
  parameter int unsigned ADDR_W      = 24,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
  input  logic clock,
  input  logic reset,
  input  logic spi_csb,
  input  logic spi_sck,
  input  logic spi_sdi,
  output logic spi_sdo,
  output logic spi_sdo_oeb,
  flash_spi_responder_if.master mem
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_IGNORE} state_t;
  typedef enum logic [1:0] {MD_READ, MD_STATUS, MD_ID} mode_t;

  // Selects one of the JEDEC ID bytes; anything past the third is zero.
  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = JEDEC_ID[23:16];
      2'd1:    b = JEDEC_ID[15:8];
      2'd2:    b = JEDEC_ID[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic              csb_meta_q, csb_sync_q;
  logic              sck_meta_q, sck_sync_q, sck_dly_q;
  logic              sdi_meta_q, sdi_sync_q;
  logic [1:0]        vld_q;
  logic              armed_q, armed_d;
  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [22:0]       shin_q, shin_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d, rd_dly_q;
  logic [7:0]        nxt_q, nxt_d, out_q, out_d;
  logic              sdo_q, sdo_d, oeb_q, oeb_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0]        fcnt_q, fcnt_d, rcnt_q, rcnt_d;
  logic              sck_rise_s, sck_fall_s;
  logic [23:0]       rx_s;
  logic              unused_s;

  assign sck_rise_s = sck_sync_q & ~sck_dly_q;
  assign sck_fall_s = ~sck_sync_q & sck_dly_q;
  // Incoming bit appended to what has been shifted in so far.
  assign rx_s       = {shin_q, sdi_sync_q};
  assign unused_s   = ^rx_s;

  assign spi_sdo       = sdo_q;
  assign spi_sdo_oeb   = oeb_q;
  assign mem.mem_rd    = rd_q;
  assign mem.mem_addr  = addr_q;

  // Two-flop synchronizers plus the delayed sck copy used for edge detection.
  // vld_q marks when the synchronized values reflect the real pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      csb_meta_q <= 1'b1;
      csb_sync_q <= 1'b1;
      sck_meta_q <= 1'b0;
      sck_sync_q <= 1'b0;
      sck_dly_q  <= 1'b0;
      sdi_meta_q <= 1'b0;
      sdi_sync_q <= 1'b0;
      vld_q      <= 2'b00;
    end else begin
      csb_meta_q <= spi_csb;
      csb_sync_q <= csb_meta_q;
      sck_meta_q <= spi_sck;
      sck_sync_q <= sck_meta_q;
      sck_dly_q  <= sck_sync_q;
      sdi_meta_q <= spi_sdi;
      sdi_sync_q <= sdi_meta_q;
      vld_q      <= {vld_q[0], 1'b1};
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MD_READ;
      armed_q  <= 1'b0;
      cnt_q    <= 5'd0;
      shin_q   <= 23'd0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      rd_dly_q <= 1'b0;
      nxt_q    <= 8'h00;
      out_q    <= 8'h00;
      sdo_q    <= 1'b0;
      oeb_q    <= 1'b1;
      idx_q    <= 2'd0;
      fcnt_q   <= 3'd0;
      rcnt_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      shin_q   <= shin_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      rd_dly_q <= rd_q;
      nxt_q    <= nxt_d;
      out_q    <= out_d;
      sdo_q    <= sdo_d;
      oeb_q    <= oeb_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
      rcnt_q   <= rcnt_d;
    end
  end

  // Next-state decode: command/address shifting, fetch strobes, output shifting.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    shin_d  = shin_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    out_d   = out_q;
    sdo_d   = sdo_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    rcnt_d  = rcnt_q;
    // A frame may only start once csb has genuinely been seen high after reset.
    armed_d = armed_q | (vld_q[1] & csb_sync_q);
    // Memory data arrives one cycle after the strobe; park it in the buffer.
    if (rd_dly_q && (mode_q == MD_READ)) begin
      nxt_d = mem.mem_rdata;
    end else begin
      nxt_d = nxt_q;
    end

    if (!vld_q[1]) begin
      state_d = ST_IDLE;
    end else if (csb_sync_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d = ST_CMD;
            cnt_d   = 5'd0;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_CMD: begin
          if (sck_rise_s) begin
            shin_d = rx_s[22:0];
            if (cnt_q == 5'd7) begin
              cnt_d  = 5'd0;
              fcnt_d = 3'd0;
              rcnt_d = 3'd0;
              case (rx_s[7:0])
                8'h03: state_d = ST_ADDR;
                8'h05: begin
                  state_d = ST_DATA;
                  mode_d  = MD_STATUS;
                  nxt_d   = STATUS_BYTE;
                end
                8'h9F: begin
                  state_d = ST_DATA;
                  mode_d  = MD_ID;
                  nxt_d   = id_byte(2'd0);
                  idx_d   = 2'd1;
                end
                default: state_d = ST_IGNORE;
              endcase
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_ADDR: begin
          if (sck_rise_s) begin
            shin_d = rx_s[22:0];
            if (cnt_q == 5'd23) begin
              cnt_d   = 5'd0;
              state_d = ST_DATA;
              mode_d  = MD_READ;
              addr_d  = rx_s[ADDR_W-1:0];
              rd_d    = 1'b1;
              fcnt_d  = 3'd0;
              rcnt_d  = 3'd0;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_DATA: begin
          if (sck_fall_s) begin
            // First fall of a byte loads the buffer; later falls shift it out.
            if (fcnt_q == 3'd0) begin
              sdo_d = nxt_q[7];
              out_d = {nxt_q[6:0], 1'b0};
            end else begin
              sdo_d = out_q[7];
              out_d = {out_q[6:0], 1'b0};
            end
            fcnt_d = fcnt_q + 3'd1;
          end else if (sck_rise_s) begin
            if (rcnt_q == 3'd7) begin
              rcnt_d = 3'd0;
              case (mode_q)
                MD_READ: begin
                  addr_d = addr_q + ADDR_W'(1'b1);
                  rd_d   = 1'b1;
                end
                MD_ID: begin
                  nxt_d = id_byte(idx_q);
                  if (idx_q != 2'd3) begin
                    idx_d = idx_q + 2'd1;
                  end else begin
                    idx_d = idx_q;
                  end
                end
                default: nxt_d = STATUS_BYTE;
              endcase
            end else begin
              rcnt_d = rcnt_q + 3'd1;
            end
          end else begin
            fcnt_d = fcnt_q;
          end
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // Pin is only driven while serving data.
    if (state_d != ST_DATA) begin
      sdo_d = 1'b0;
    end else begin
      sdo_d = sdo_d;
    end
    oeb_d = (state_d != ST_DATA);
  end

endmodule
